// File: rtl/charlie_scan.sv
// charlie_scan: charlieplex LED matrix scanner for N_PINS tri-state pads.
//
// Walks every (row, col) position of an N_PINS x N_PINS matrix, drives one
// LED at a time for a programmable dwell with PWM brightness, and inserts
// all-tristate blanking before every driven slot so the previous LED cannot
// ghost. The frame shown is held in a display buffer that is only refreshed
// at the start of a frame, so a frame is never torn.
//
// Handshake: frame_in/frame_valid are sampled only in the single LOAD cycle
// at the start of each frame; if frame_valid is high then, frame_in is
// copied into the display buffer, otherwise the old frame repeats.
// frame_ready (registered, so visible one clock after LOAD) marks that a
// sample point has just been taken.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        run scanner; low returns to IDLE (buffer kept)
//   frame_in      candidate frame, bit r*N_PINS+c = LED row r, col c
//   frame_valid   frame_in holds a new frame
//   frame_ready   registered LOAD indication
//   dwell         slot length minus one, in clocks (sampled live)
//   duty          driven clocks per slot (sampled live)
//   skip_dark     fast-skip diagonal and unlit positions (sampled live)
//   frame_start   registered one-cycle pulse marking LOAD
//   pin_out       pad output values
//   pin_oe        pad output enables, 1 = drive
module charlie_scan #(
   parameter int N_PINS       = 8,
   parameter int DWELL_W      = 8,
   parameter int BLANK_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic [N_PINS*N_PINS-1:0]   frame_in,
   input  logic                       frame_valid,
   output logic                       frame_ready,
   input  logic [DWELL_W-1:0]         dwell,
   input  logic [DWELL_W-1:0]         duty,
   input  logic                       skip_dark,
   output logic                       frame_start,
   output logic [N_PINS-1:0]          pin_out,
   output logic [N_PINS-1:0]          pin_oe
);

   localparam int NB = N_PINS * N_PINS;
   localparam int IW = $clog2(NB);
   localparam int RW = $clog2(N_PINS);
   localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [RW-1:0] LAST_RC    = RW'(N_PINS - 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_BLANK = 2'd2,
      S_DRIVE = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [NB-1:0]       fb_q, fb_d;
   logic [RW-1:0]       row_q, row_d;
   logic [RW-1:0]       col_q, col_d;
   logic [DWELL_W-1:0]  cnt_q, cnt_d;
   logic [BW-1:0]       bcnt_q, bcnt_d;
   logic [N_PINS-1:0]   pin_out_q, pin_out_d;
   logic [N_PINS-1:0]   pin_oe_q, pin_oe_d;
   logic                frame_ready_q, frame_ready_d;
   logic                frame_start_q, frame_start_d;

   // Separate row/col counters keep the position walk correct for any
   // N_PINS; the flat index is only needed to address the buffer.
   logic [IW-1:0]       idx;
   logic                is_diag;
   logic                led_lit;
   logic                is_dark;
   logic                last_pos;
   logic                step;
   logic                drive;

   assign idx      = IW'(row_q) * IW'(N_PINS) + IW'(col_q);
   assign is_diag  = (row_q == col_q);
   assign led_lit  = fb_q[idx];
   assign is_dark  = is_diag || !led_lit;
   assign last_pos = (row_q == LAST_RC) && (col_q == LAST_RC);

   always_comb begin
      state_d       = state_q;
      fb_d          = fb_q;
      row_d         = row_q;
      col_d         = col_q;
      cnt_d         = cnt_q;
      bcnt_d        = bcnt_q;
      step          = 1'b0;
      drive         = 1'b0;
      pin_oe_d      = '0;
      pin_out_d     = '0;
      frame_ready_d = (state_q == S_LOAD);
      frame_start_d = (state_q == S_LOAD);

      case (state_q)
         S_IDLE: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            if (frame_valid) begin
               fb_d = frame_in;
            end
            row_d   = '0;
            col_d   = '0;
            bcnt_d  = '0;
            state_d = S_BLANK;
         end
         S_BLANK: begin
            // The skip decision is made only on the first blank clock of a
            // position, so a skipped position costs exactly one clock.
            if ((bcnt_q == '0) && skip_dark && is_dark) begin
               step = 1'b1;
            end else if (bcnt_q == BLANK_LAST) begin
               cnt_d   = '0;
               state_d = S_DRIVE;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
         S_DRIVE: begin
            drive = (cnt_q < duty) && !is_dark;
            // >= rather than == so a live reduction of dwell below the
            // running count still ends the slot instead of wrapping.
            if (cnt_q >= dwell) begin
               step = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (step) begin
         if (last_pos) begin
            state_d = S_LOAD;
         end else begin
            state_d = S_BLANK;
            bcnt_d  = '0;
            if (col_q == LAST_RC) begin
               col_d = '0;
               row_d = row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
      end

      if (!enable) begin
         state_d = S_IDLE;
         row_d   = '0;
         col_d   = '0;
         cnt_d   = '0;
         bcnt_d  = '0;
      end

      // Row sources current, column sinks it; everything else floats.
      if (drive) begin
         pin_oe_d[row_q]  = 1'b1;
         pin_oe_d[col_q]  = 1'b1;
         pin_out_d[row_q] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         fb_q          <= '0;
         row_q         <= '0;
         col_q         <= '0;
         cnt_q         <= '0;
         bcnt_q        <= '0;
         pin_out_q     <= '0;
         pin_oe_q      <= '0;
         frame_ready_q <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         fb_q          <= fb_d;
         row_q         <= row_d;
         col_q         <= col_d;
         cnt_q         <= cnt_d;
         bcnt_q        <= bcnt_d;
         pin_out_q     <= pin_out_d;
         pin_oe_q      <= pin_oe_d;
         frame_ready_q <= frame_ready_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign pin_out     = pin_out_q;
   assign pin_oe      = pin_oe_q;
   assign frame_ready = frame_ready_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_charlie_scan.sv
// tb_charlie_scan: self-checking bench for charlie_scan (N_PINS=8).
// Expected per-clock output words {frame_start, frame_ready, pin_oe,
// pin_out} for a whole frame are pushed to exp_q from the frame contents
// and scan settings, then popped and compared clock by clock once the
// frame_start pulse is seen.
module tb_charlie_scan;

   localparam int N     = 8;
   localparam int NB    = N * N;
   localparam int DW    = 8;
   localparam int BLANK = 1;
   localparam int W     = 2 + 2 * N;

   logic            clk;
   logic            rst_n;
   logic            enable;
   logic [NB-1:0]   frame_in;
   logic            frame_valid;
   logic            frame_ready;
   logic [DW-1:0]   dwell;
   logic [DW-1:0]   duty;
   logic            skip_dark;
   logic            frame_start;
   logic [N-1:0]    pin_out;
   logic [N-1:0]    pin_oe;

   logic [W-1:0]    exp_q[$];
   int              errors = 0;
   int              checks = 0;

   charlie_scan #(
      .N_PINS       (N),
      .DWELL_W      (DW),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .frame_in    (frame_in),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .dwell       (dwell),
      .duty        (duty),
      .skip_dark   (skip_dark),
      .frame_start (frame_start),
      .pin_out     (pin_out),
      .pin_oe      (pin_oe)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- expectation builder ----------------
   // One frame as seen on the registered outputs, starting with the
   // frame_start clock: 1 LOAD clock, then per position either one clock
   // (skipped) or BLANK idle clocks followed by dwell+1 slot clocks.
   function automatic void push_frame(input logic [NB-1:0] fb, input int dw,
                                      input int du, input bit skip);
      logic [N-1:0] oe;
      logic [N-1:0] out;
      int r;
      int c;
      bit dark;
      exp_q.push_back({1'b1, 1'b1, {N{1'b0}}, {N{1'b0}}});
      for (int i = 0; i < NB; i++) begin
         r = i / N;
         c = i % N;
         dark = (r == c) || !fb[i];
         if (skip && dark) begin
            exp_q.push_back('0);
         end else begin
            for (int b = 0; b < BLANK; b++) exp_q.push_back('0);
            for (int k = 0; k <= dw; k++) begin
               oe  = '0;
               out = '0;
               if (k < du && !dark) begin
                  oe[r]  = 1'b1;
                  oe[c]  = 1'b1;
                  out[r] = 1'b1;
               end
               exp_q.push_back({2'b00, oe, out});
            end
         end
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic wait_frame_start(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (frame_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_drive(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (pin_oe !== '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst_n       = 1'b0;
      enable      = 1'b0;
      frame_in    = '0;
      frame_valid = 1'b0;
      dwell       = 8'd3;
      duty        = 8'd4;
      skip_dark   = 1'b0;
      #3;
      checks++;
      if ({frame_start, frame_ready, pin_oe, pin_out} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got=%h want=0",
                  {frame_start, frame_ready, pin_oe, pin_out});
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({frame_start, frame_ready, pin_oe, pin_out} !== '0) begin
            errors++;
            $display("FAIL idle_outputs cyc=%0d got=%h want=0", i,
                     {frame_start, frame_ready, pin_oe, pin_out});
         end
      end
   endtask

   task automatic test_single_led;
      bit ok;
      logic [W-1:0] ew;
      int cyc;
      int lit;
      frame_in    = 64'h2;
      frame_valid = 1'b1;
      enable      = 1'b1;
      wait_frame_start(10, ok);
      frame_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_first_start got=timeout want=pulse");
      end
      for (int f = 0; f < 2; f++) begin
         if (f > 0) @(negedge clk);
         push_frame(64'h2, 3, 4, 1'b0);
         cyc = 0;
         lit = 0;
         while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            checks++;
            if ({frame_start, frame_ready, pin_oe, pin_out} !== ew) begin
               errors++;
               $display("FAIL single_led f=%0d cyc=%0d got=%h want=%h", f, cyc,
                        {frame_start, frame_ready, pin_oe, pin_out}, ew);
            end
            if (pin_oe === 8'h03 && pin_out === 8'h01) lit++;
            cyc++;
            if (exp_q.size() > 0) @(negedge clk);
         end
         checks++;
         if (lit !== 4) begin
            errors++;
            $display("FAIL single_led_lit_clocks got=%0d want=4", lit);
         end
      end
      @(negedge clk);
      checks++;
      if (frame_start !== 1'b1) begin
         errors++;
         $display("FAIL single_led_period got=%b want=1 at clock 321", frame_start);
      end
   endtask

   task automatic test_skip_dark;
      bit ok;
      logic [W-1:0] ew;
      int cyc;
      skip_dark = 1'b1;
      // Already on the frame_start clock of the first fully skipped frame.
      push_frame(64'h2, 3, 4, 1'b1);
      cyc = 0;
      while (exp_q.size() > 0) begin
         ew = exp_q.pop_front();
         checks++;
         if ({frame_start, frame_ready, pin_oe, pin_out} !== ew) begin
            errors++;
            $display("FAIL skip_dark cyc=%0d got=%h want=%h", cyc,
                     {frame_start, frame_ready, pin_oe, pin_out}, ew);
         end
         cyc++;
         if (exp_q.size() > 0) @(negedge clk);
      end
      wait_frame_start(69, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL skip_dark_period got=timeout want=69");
      end
      // Leave on the last clock of this frame for the next test.
      push_frame(64'h2, 3, 4, 1'b1);
      void'(exp_q.pop_front());
      while (exp_q.size() > 0) begin
         void'(exp_q.pop_front());
         @(negedge clk);
      end
   endtask

   task automatic test_pwm;
      bit ok;
      logic [W-1:0] ew;
      int cyc;
      int first_lit;
      int lit;
      frame_in    = 64'h400;
      frame_valid = 1'b1;
      skip_dark   = 1'b0;
      duty        = 8'd2;
      wait_frame_start(400, ok);
      frame_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL pwm_start got=timeout want=pulse");
      end
      push_frame(64'h400, 3, 2, 1'b0);
      cyc = 0;
      lit = 0;
      first_lit = -1;
      while (exp_q.size() > 0) begin
         ew = exp_q.pop_front();
         checks++;
         if ({frame_start, frame_ready, pin_oe, pin_out} !== ew) begin
            errors++;
            $display("FAIL pwm cyc=%0d got=%h want=%h", cyc,
                     {frame_start, frame_ready, pin_oe, pin_out}, ew);
         end
         if (pin_oe === 8'h06 && pin_out === 8'h02) begin
            lit++;
            if (first_lit < 0) first_lit = cyc;
         end
         cyc++;
         if (exp_q.size() > 0) @(negedge clk);
      end
      checks++;
      // LOAD, then 10 positions of 5 clocks, then one blank clock.
      if (lit !== 2 || first_lit !== 52) begin
         errors++;
         $display("FAIL pwm_window got=lit%0d@%0d want=lit2@52", lit, first_lit);
      end
   endtask

   task automatic test_frame_swap;
      logic [W-1:0] ew;
      int cyc;
      int rdy;
      push_frame(64'h400, 3, 2, 1'b0);
      @(negedge clk);
      cyc = 0;
      rdy = 0;
      while (exp_q.size() > 0) begin
         ew = exp_q.pop_front();
         checks++;
         if ({frame_start, frame_ready, pin_oe, pin_out} !== ew) begin
            errors++;
            $display("FAIL swap_old cyc=%0d got=%h want=%h", cyc,
                     {frame_start, frame_ready, pin_oe, pin_out}, ew);
         end
         if (cyc > 100 && frame_ready === 1'b1) rdy++;
         if (cyc == 100) begin
            frame_in    = 64'h10_0000;
            frame_valid = 1'b1;
         end
         cyc++;
         if (exp_q.size() > 0) @(negedge clk);
      end
      checks++;
      if (rdy !== 0) begin
         errors++;
         $display("FAIL swap_ready_midframe got=%0d want=0", rdy);
      end
      for (int f = 0; f < 2; f++) begin
         push_frame(64'h10_0000, 3, 2, 1'b0);
         @(negedge clk);
         cyc = 0;
         while (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            checks++;
            if ({frame_start, frame_ready, pin_oe, pin_out} !== ew) begin
               errors++;
               $display("FAIL swap_new f=%0d cyc=%0d got=%h want=%h", f, cyc,
                        {frame_start, frame_ready, pin_oe, pin_out}, ew);
            end
            frame_valid = 1'b0;
            cyc++;
            if (exp_q.size() > 0) @(negedge clk);
         end
      end
   endtask

   task automatic test_diag;
      bit ok;
      logic [W-1:0] ew;
      int cyc;
      int bad;
      frame_in    = 64'h201;
      frame_valid = 1'b1;
      duty        = 8'd4;
      wait_frame_start(400, ok);
      frame_valid = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL diag_start got=timeout want=pulse");
      end
      push_frame(64'h201, 3, 4, 1'b0);
      cyc = 0;
      bad = 0;
      while (exp_q.size() > 0) begin
         ew = exp_q.pop_front();
         checks++;
         if ({frame_start, frame_ready, pin_oe, pin_out} !== ew) begin
            errors++;
            $display("FAIL diag cyc=%0d got=%h want=%h", cyc,
                     {frame_start, frame_ready, pin_oe, pin_out}, ew);
         end
         if ($countones(pin_oe) > 2 || pin_oe[0] !== 1'b0) bad++;
         cyc++;
         if (exp_q.size() > 0) @(negedge clk);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL diag_pin_rule got=%0d want=0", bad);
      end
   endtask

   task automatic test_enable_low;
      bit ok;
      logic [W-1:0] ew;
      int cyc;
      frame_in    = 64'h400;
      frame_valid = 1'b1;
      duty        = 8'd2;
      wait_frame_start(400, ok);
      frame_valid = 1'b0;
      wait_drive(100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL enable_drive got=timeout want=drive");
      end
      enable = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({frame_start, frame_ready, pin_oe, pin_out} !== '0) begin
            errors++;
            $display("FAIL enable_low cyc=%0d got=%h want=0", i,
                     {frame_start, frame_ready, pin_oe, pin_out});
         end
      end
      enable = 1'b1;
      wait_frame_start(5, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL enable_restart got=timeout want=pulse");
      end
      push_frame(64'h400, 3, 2, 1'b0);
      cyc = 0;
      while (exp_q.size() > 0) begin
         ew = exp_q.pop_front();
         checks++;
         if ({frame_start, frame_ready, pin_oe, pin_out} !== ew) begin
            errors++;
            $display("FAIL enable_retain cyc=%0d got=%h want=%h", cyc,
                     {frame_start, frame_ready, pin_oe, pin_out}, ew);
         end
         cyc++;
         if (exp_q.size() > 0) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_drive;
      bit ok;
      logic [W-1:0] ew;
      int cyc;
      frame_in    = 64'h2;
      frame_valid = 1'b1;
      duty        = 8'd4;
      wait_frame_start(400, ok);
      frame_valid = 1'b0;
      wait_drive(100, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rst_mid_drive_reach got=timeout want=drive");
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({frame_start, frame_ready, pin_oe, pin_out} !== '0) begin
         errors++;
         $display("FAIL rst_async got=%h want=0",
                  {frame_start, frame_ready, pin_oe, pin_out});
      end
      @(negedge clk);
      #1 rst_n = 1'b1;
      wait_frame_start(5, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rst_restart got=timeout want=pulse");
      end
      // Buffer was cleared by reset and no new frame is offered.
      push_frame('0, 3, 4, 1'b0);
      cyc = 0;
      while (exp_q.size() > 0) begin
         ew = exp_q.pop_front();
         checks++;
         if ({frame_start, frame_ready, pin_oe, pin_out} !== ew) begin
            errors++;
            $display("FAIL rst_cleared cyc=%0d got=%h want=%h", cyc,
                     {frame_start, frame_ready, pin_oe, pin_out}, ew);
         end
         cyc++;
         if (exp_q.size() > 0) @(negedge clk);
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_single_led();
      test_skip_dark();
      test_pwm();
      test_frame_swap();
      test_diag();
      test_enable_low();
      test_reset_mid_drive();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/charlie_scan.md
Name: charlie_scan

Overview:
- Parametrised charlieplex LED matrix scanner for N_PINS tri-state pins (N_PINS*(N_PINS-1) usable LEDs).
- Owns its own scan counter, per-LED dwell timing, global PWM brightness, anti-ghost blanking and a double-buffered frame input with valid/ready handshake.
- Sits between the frame generator and the bidirectional uio pads.

Parameters:
- N_PINS, 8, number of charlieplex pins; matrix is N_PINS x N_PINS, diagonal unused.
- DWELL_W, 8, width of the dwell and duty inputs and of the dwell counter.
- BLANK_CYCLES, 1, all-pins-tristate cycles before each driven LED slot (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run scanner; low forces IDLE.
- frame_in  in  N_PINS*N_PINS  candidate frame; bit r*N_PINS+c = LED row r, col c.
- frame_valid  in  1  frame_in holds a new frame.
- frame_ready  out  1  scanner accepts frame this cycle.
- dwell  in  DWELL_W  slot length minus one, in clocks.
- duty  in  DWELL_W  driven clocks per slot (PWM brightness).
- skip_dark  in  1  fast-skip diagonal and unlit positions.
- frame_start  out  1  one-cycle pulse in LOAD.
- pin_out  out  N_PINS  pad output values.
- pin_oe  out  N_PINS  pad output enables, 1 = drive.

Behaviour:
- Reset (async): state IDLE; display buffer, index and counters 0; pin_out, pin_oe, frame_ready and frame_start all 0.
- Index idx in 0..N_PINS*N_PINS-1; row = idx / N_PINS, col = idx % N_PINS. For power-of-two N_PINS this is a bit split; otherwise use separate row and col counters with wrap.
- IDLE: pins all 0. enable=1 -> LOAD.
- LOAD (1 cycle):
  - frame_ready=1 and frame_start=1.
  - If frame_valid, copy frame_in into the display buffer; otherwise keep the previous buffer.
  - idx <- 0; go to BLANK.
- BLANK:
  - On the first cycle at an idx, if skip_dark=1 and (row==col or the buffer bit is 0): skip the slot. idx+1 (or LOAD if last) next cycle; 1 clock per skipped position.
  - Otherwise hold all pins tristate for BLANK_CYCLES clocks, clear cnt, go to DRIVE.
- DRIVE:
  - cnt counts 0..dwell, so the slot is dwell+1 clocks.
  - LED is driven when cnt < duty, the buffer bit is 1 and row != col.
  - Drive pattern: pin_oe[row]=1, pin_oe[col]=1, pin_out[row]=1, pin_out[col]=0; all other bits 0.
  - When not driving: pin_oe=0, pin_out=0.
  - At cnt==dwell: last idx -> LOAD, else idx+1 -> BLANK.
- Diagonal positions are never driven, regardless of buffer contents.
- duty=0: LEDs never driven. duty > dwell: driven for the whole slot.
- dwell, duty and skip_dark are sampled live each cycle. A change takes effect at the next comparison and needs no restart.
- frame_ready is high only in LOAD. frame_in is never sampled mid-frame, so there is no tearing.
- enable=0 in any state: next clock state=IDLE, idx=0. The registered pins go 0 one clock later. The display buffer is retained.
- Pins, frame_ready and frame_start are registered. They lag the internal state/cnt decode by exactly 1 clock.
- Frame period in clocks = 1 (LOAD) + per non-skipped position (BLANK_CYCLES + dwell + 1) + per skipped position 1.
- At most two pins are ever enabled simultaneously, and never two pins driven high.

Test Plan:
- Reset mid-DRIVE: assert rst_n=0 asynchronously -> pin_oe=0x00, pin_out=0x00, frame_ready=0 without waiting for a clock edge; after release with enable=1, first frame_start follows.
- N_PINS=8, frame bit 1 (row 0, col 1) only, dwell=3, duty=4, skip_dark=0 -> pin_oe=0x03, pin_out=0x01 for 4 consecutive clocks per frame; frame_start pulses every 321 clocks.
- Same frame, skip_dark=1 -> frame_start every 69 clocks (1 + 63 + 5); same 4-clock drive pattern.
- duty=2, dwell=3, bit 10 (row 1, col 2) -> pin_oe=0x06, pin_out=0x02 for 2 clocks, then 0x00 for 2 clocks, then the blank cycle.
- Raise frame_valid mid-scan with a new frame -> frame_ready stays 0 until LOAD; the new pattern appears only after the next frame_start. With frame_valid=0 at LOAD, the old frame repeats.
- Bit 0 (diagonal) and bit 9 set, skip_dark=0 -> pins never show row 0/col 0 drive; pin_oe never has more than 2 bits set over a full frame.
